// File: rtl/sp_ram_pipe.sv
// sp_ram_pipe: single-port byte-enabled RAM with power-on clear and pipelined read responses.
module sp_ram_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                init_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB = DATA_W / 8;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_w, merged, sel;
  logic acc, resp;
  logic p_v, o_v;
  logic [DATA_W-1:0] p_d, o_d;
  assign ready = state == RUN;
  assign init_done = state == RUN;
  assign acc = req && ready;
  assign old_w = mem[addr];
  assign resp = acc && (!we || RDW_MODE != 2);
  assign sel = (we && RDW_MODE == 0) ? merged : old_w;
  always_comb begin
    merged = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end
  always_comb state_nx = (state == INIT && &cnt) ? RUN : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == INIT) ? cnt + 1'b1 : cnt;
    end
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt] <= '0;
    else if (acc && we) mem[addr] <= merged;
  // p_* captures the array word at acceptance, o_* is the response register one edge later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_v <= 1'b0;
      p_d <= '0;
      o_v <= 1'b0;
      o_d <= '0;
    end else begin
      p_v <= resp;
      if (resp) p_d <= sel;
      o_v <= p_v;
      if (p_v) o_d <= p_d;
    end
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic q_v;
      logic [DATA_W-1:0] q_d;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          q_v <= 1'b0;
          q_d <= '0;
        end else begin
          q_v <= o_v;
          if (o_v) q_d <= o_d;
        end
      assign rvalid = q_v;
      assign rdata = q_d;
    end else begin : g_noreg
      assign rvalid = o_v;
      assign rdata = o_d;
    end
  endgenerate
endmodule

// File: doc/sp_ram_pipe.md
SP_RAM_PIPE -- requirements
Module: sp_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 6: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
REQ-004 SHALL have parameter RDW_MODE, default 0: write-port read behaviour. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named as the codebase names them.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req  input  1  access request; accepted when req && ready at a rising edge.
REQ-009 we  input  1  1 = write, 0 = read; sampled with req.
REQ-010 addr  input  ADDR_W  word address.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 be  input  DATA_W/8  byte enables; be[i] gates wdata[8i+7:8i].
REQ-013 ready  output  1  access can be accepted this cycle.
REQ-014 rdata  output  DATA_W  read data; holds its last value when rvalid=0.
REQ-015 rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-016 init_done  output  1  memory clear complete.

Function
REQ-017 FSM states SHALL be INIT and RUN; reset SHALL force INIT with clear counter = 0.
REQ-018 In INIT: one word per cycle SHALL be written to all-zero at the counter address, incrementing 0..DEPTH-1; req SHALL be ignored and ready = 0.
REQ-019 INIT -> RUN SHALL occur on the edge that writes address DEPTH-1; ready and init_done SHALL be 1 from the following cycle, i.e. DEPTH cycles after reset release.
REQ-020 In RUN: ready SHALL be 1 every cycle; back-to-back accesses SHALL be accepted each cycle with no bubbles.
REQ-021 Accepted write: for each i with be[i]=1, the byte SHALL be updated at that edge; disabled bytes SHALL keep their value; be=0 is a legal no-op write.
REQ-022 Accepted read at edge N: rdata = mem[addr] with rvalid=1 SHALL appear after edge N+1 if OUT_REG=0, or after edge N+2 if OUT_REG=1.
REQ-023 Write with WRITE_FIRST: rvalid SHALL pulse with the merged post-write word at read latency.
REQ-024 Write with READ_FIRST: rvalid SHALL pulse with the pre-write word at read latency.
REQ-025 Write with NO_CHANGE: no rvalid pulse; rdata SHALL be unchanged.
REQ-026 A read immediately following a write to the same address SHALL return the written data (no stale read).
REQ-027 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.
REQ-028 With OUT_REG=1, the rvalid/rdata pipeline SHALL hold up to 2 responses in flight, in order, with no loss.

Reset
REQ-029 Reset SHALL asynchronously drive ready=0, init_done=0, rvalid=0, rdata=0, and discard in-flight responses.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the clear from address 0 after release; array contents are not cleared by reset itself, only by INIT.
REQ-031 After reset release, the first req SHALL be accepted only once ready=1.

Verification
REQ-032 Bench SHALL cover: DATA_W=32, ADDR_W=4, release reset -> ready=0 for 16 cycles then 1; reads of all 16 addresses return 0x00000000.
REQ-033 Bench SHALL cover: write addr 3 data 0xAABBCCDD be=4'b1111, then write addr 3 data 0x11223344 be=4'b0101 -> read addr 3 returns 0xAA22CC44, rvalid 1 cycle after acceptance (OUT_REG=0), 2 cycles after (OUT_REG=1).
REQ-034 Bench SHALL cover: mem[5]=0x12345678; write addr 5 0xCAFEF00D be=4'b1111 -> rvalid with 0xCAFEF00D (WRITE_FIRST), with 0x12345678 (READ_FIRST), no rvalid and rdata unchanged (NO_CHANGE).
REQ-035 Bench SHALL cover: back-to-back reads of addr 0,1,2,3 on 4 consecutive cycles (OUT_REG=1) -> 4 consecutive rvalid pulses with data in order.
REQ-036 Bench SHALL cover: assert rst while 2 reads are in flight -> rvalid=0 and rdata=0 immediately; after release, full INIT runs again and memory reads 0.
REQ-037 Bench SHALL cover: req=1 during INIT -> no write occurs, no rvalid, memory still all zero after INIT.
